// File: rtl/cyclic_decoder_if.sv
// ---------------------------------------------------------------------------
// cyclic_decoder_if
// Handshake/bus bundle between a producer of received codewords and the
// cyclic_decoder, plus the result path towards the data consumer.
//
//   g                 generator coefficients x^0..x^(M-1), x^M implied
//   code_in           received word, [N-1:M] data, [M-1:0] parity
//   in_valid/in_ready input handshake
//   code_out          corrected codeword
//   data_out          data field of code_out
//   err_pos           index of the corrected bit
//   err_corrected     a single-bit error was fixed
//   err_uncorrectable nonzero syndrome matching no single-bit pattern
//   out_valid/out_ready result handshake
//   syndrome_out      final syndrome (only with CYCLIC_DECODER_SYNDROME_OUT_EN)
//
// Modports: slave = decoder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface cyclic_decoder_if #(
  parameter int N  = 15,
  parameter int K  = 5,
  parameter int M  = N - K,
  parameter int PW = $clog2(N)
) ();
  logic [M-1:0]  g;
  logic [N-1:0]  code_in;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  code_out;
  logic [K-1:0]  data_out;
  logic [PW-1:0] err_pos;
  logic          err_corrected;
  logic          err_uncorrectable;
  logic          out_valid;
  logic          out_ready;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
  logic [M-1:0]  syndrome_out;
`endif

  modport slave (
    input  g, code_in, in_valid, out_ready,
    output in_ready, code_out, data_out, err_pos,
           err_corrected, err_uncorrectable, out_valid
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
    , output syndrome_out
`endif
  );

  modport master (
    output g, code_in, in_valid, out_ready,
    input  in_ready, code_out, data_out, err_pos,
           err_corrected, err_uncorrectable, out_valid
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
    , input syndrome_out
`endif
  );
endinterface

// File: rtl/cyclic_decoder.sv
// ---------------------------------------------------------------------------
// cyclic_decoder
// Single-error-correcting decoder for systematic (N,K) cyclic codes.
// A received word is captured, its syndrome r(x) mod g(x) is formed serially
// (MSB first) in a generator LFSR, and a nonzero syndrome is matched against
// x^j mod g(x) for j = 0..N-1 to locate a single flipped bit.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    cyclic_decoder_if.slave (input word/generator, result and status)
//
// Optional feature: define CYCLIC_DECODER_SYNDROME_OUT_EN to add
// bus.syndrome_out, the final syndrome held from DONE entry until the next
// syndrome computation completes.
// ---------------------------------------------------------------------------
module cyclic_decoder #(
  parameter int N  = 15,
  parameter int K  = 5,
  parameter int M  = N - K,
  parameter int PW = $clog2(N)
) (
  input logic              clk,
  input logic              reset,
  cyclic_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    SRCH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [M-1:0]  g_q, g_d;
  logic [M-1:0]  s_q, s_d;
  logic [M-1:0]  e_q, e_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] j_q, j_d;
  logic [N-1:0]  code_out_q, code_out_d;
  logic [PW-1:0] err_pos_q, err_pos_d;
  logic          err_corr_q, err_corr_d;
  logic          err_unc_q, err_unc_d;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
  logic [M-1:0]  syn_q, syn_d;
`endif

  logic          bit_s;
  logic [M-1:0]  s_next_s;
  logic [M-1:0]  e_next_s;

  // Received bits enter MSB first; the feedback tap folds x^M back through g.
  assign bit_s    = r_q[PW'(N-1) - cnt_q];
  assign s_next_s = {s_q[M-2:0], bit_s} ^ (s_q[M-1] ? g_q : {M{1'b0}});
  // Next error-locator candidate x^(j+1) mod g(x).
  assign e_next_s = {e_q[M-2:0], 1'b0} ^ (e_q[M-1] ? g_q : {M{1'b0}});

  // State register and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      r_q        <= {N{1'b0}};
      g_q        <= {M{1'b0}};
      s_q        <= {M{1'b0}};
      e_q        <= {M{1'b0}};
      cnt_q      <= {PW{1'b0}};
      j_q        <= {PW{1'b0}};
      code_out_q <= {N{1'b0}};
      err_pos_q  <= {PW{1'b0}};
      err_corr_q <= 1'b0;
      err_unc_q  <= 1'b0;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
      syn_q      <= {M{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      g_q        <= g_d;
      s_q        <= s_d;
      e_q        <= e_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      code_out_q <= code_out_d;
      err_pos_q  <= err_pos_d;
      err_corr_q <= err_corr_d;
      err_unc_q  <= err_unc_d;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
      syn_q      <= syn_d;
`endif
    end
  end

  // Next-state and datapath update for the capture/syndrome/search sequence.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    g_d        = g_q;
    s_d        = s_q;
    e_d        = e_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    code_out_d = code_out_q;
    err_pos_d  = err_pos_q;
    err_corr_d = err_corr_q;
    err_unc_d  = err_unc_q;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
    syn_d      = syn_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r_d     = bus.code_in;
          g_d     = bus.g;
          s_d     = {M{1'b0}};
          cnt_d   = {PW{1'b0}};
          state_d = SYND;
        end else begin
          state_d = IDLE;
        end
      end
      SYND: begin
        s_d = s_next_s;
        if (cnt_q == PW'(N-1)) begin
          if (s_next_s == {M{1'b0}}) begin
            code_out_d = r_q;
            err_pos_d  = {PW{1'b0}};
            err_corr_d = 1'b0;
            err_unc_d  = 1'b0;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
            syn_d      = s_next_s;
`endif
            state_d    = DONE;
          end else begin
            e_d     = {{(M-1){1'b0}}, 1'b1};
            j_d     = {PW{1'b0}};
            state_d = SRCH;
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      SRCH: begin
        if (e_q == s_q) begin
          code_out_d = r_q ^ ({{(N-1){1'b0}}, 1'b1} << j_q);
          err_pos_d  = j_q;
          err_corr_d = 1'b1;
          err_unc_d  = 1'b0;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
          syn_d      = s_q;
`endif
          state_d    = DONE;
        end else if (j_q == PW'(N-1)) begin
          code_out_d = r_q;
          err_pos_d  = {PW{1'b0}};
          err_corr_d = 1'b0;
          err_unc_d  = 1'b1;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
          syn_d      = s_q;
`endif
          state_d    = DONE;
        end else begin
          e_d = e_next_s;
          j_d = j_q + PW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready          = (state_q == IDLE);
  assign bus.out_valid         = (state_q == DONE);
  assign bus.code_out          = code_out_q;
  assign bus.data_out          = code_out_q[N-1:M];
  assign bus.err_pos           = err_pos_q;
  assign bus.err_corrected     = err_corr_q;
  assign bus.err_uncorrectable = err_unc_q;
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
  assign bus.syndrome_out      = syn_q;
`endif

endmodule

// File: tb/tb_cyclic_decoder.sv
// ---------------------------------------------------------------------------
// tb_cyclic_decoder
// Self-checking bench for cyclic_decoder: directed vectors followed by
// randomized codewords with 0..2 injected errors, compared against a
// polynomial long-division reference model.
// ---------------------------------------------------------------------------
module tb_cyclic_decoder;
  localparam int N  = 15;
  localparam int K  = 5;
  localparam int M  = N - K;
  localparam int PW = $clog2(N);

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cyclic_decoder_if #(.N(N), .K(K)) dif ();

  cyclic_decoder #(.N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // r(x) mod g(x) by plain long division, g(x) = x^M + gl(x).
  function automatic logic [M-1:0] poly_mod(input logic [N-1:0] r, input logic [M-1:0] gl);
    logic [N-1:0] w;
    logic [N-1:0] gf;
    w  = r;
    gf = N'({1'b1, gl});
    for (int i = N - 1; i >= M; i--) begin
      if (w[i]) w = w ^ (gf << (i - M));
    end
    return w[M-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one word, wait for the result, check latency/outputs/handshake.
  task automatic run_word(input logic [N-1:0] r, input logic [M-1:0] gv,
                          input int hold, input bit gchange);
    logic [M-1:0]  exp_syn;
    logic [N-1:0]  exp_code;
    logic [N-1:0]  one;
    logic [PW-1:0] exp_pos;
    logic          exp_corr, exp_unc, found;
    int            exp_lat, lat;
    one      = {{(N-1){1'b0}}, 1'b1};
    exp_syn  = poly_mod(r, gv);
    exp_code = r;
    exp_pos  = '0;
    exp_corr = 1'b0;
    exp_unc  = 1'b0;
    exp_lat  = N;
    found    = 1'b0;
    if (exp_syn != '0) begin
      exp_unc = 1'b1;
      exp_lat = 2 * N;
      for (int jj = 0; jj < N; jj++) begin
        if (!found && poly_mod(one << jj, gv) == exp_syn) begin
          found    = 1'b1;
          exp_code = r ^ (one << jj);
          exp_pos  = PW'(jj);
          exp_corr = 1'b1;
          exp_unc  = 1'b0;
          exp_lat  = N + 1 + jj;
        end
      end
    end

    @(negedge clk);
    check("in_ready_idle", 32'(dif.in_ready), 32'd1);
    dif.code_in  = r;
    dif.g        = gv;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.code_in  = N'($urandom);
    check("in_ready_busy", 32'(dif.in_ready), 32'd0);
    lat = 0;
    while (!dif.out_valid && lat < 3 * N) begin
      if (gchange && lat == 3) dif.g = M'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("code_out", 32'(dif.code_out), 32'(exp_code));
    check("data_out", 32'(dif.data_out), 32'(exp_code[N-1:M]));
    check("err_corrected", 32'(dif.err_corrected), 32'(exp_corr));
    check("err_uncorrectable", 32'(dif.err_uncorrectable), 32'(exp_unc));
    if (exp_corr) check("err_pos", 32'(dif.err_pos), 32'(exp_pos));
`ifdef CYCLIC_DECODER_SYNDROME_OUT_EN
    check("syndrome_out", 32'(dif.syndrome_out), 32'(exp_syn));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(dif.out_valid), 32'd1);
      check("hold_in_ready", 32'(dif.in_ready), 32'd0);
      check("hold_code_out", 32'(dif.code_out), 32'(exp_code));
      check("hold_flags", 32'({dif.err_corrected, dif.err_uncorrectable}),
            32'({exp_corr, exp_unc}));
    end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    check("release_valid", 32'(dif.out_valid), 32'd0);
    check("release_in_ready", 32'(dif.in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] cw;
    logic [N-1:0] dword;
    logic [M-1:0] gv;
    int           nerr, b0, b1;

    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.g         = '0;
    dif.code_in   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(dif.in_ready), 32'd1);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_code_out", 32'(dif.code_out), 32'd0);
    check("rst_flags", 32'({dif.err_corrected, dif.err_uncorrectable, dif.err_pos}), 32'd0);

    // Directed words
    run_word(15'h0537, 10'h137, 0, 1'b0);  // clean
    run_word(15'h053F, 10'h137, 0, 1'b0);  // bit 3 flipped
    run_word(15'h3FFF, 10'h137, 5, 1'b0);  // bit 14 flipped, held 5 cycles
    run_word(15'h0534, 10'h137, 0, 1'b0);  // double error
    run_word(15'h053F, 10'h137, 0, 1'b1);  // g changed mid-syndrome

    // Reset during search discards the word
    @(negedge clk);
    dif.code_in  = 15'h3FFF;
    dif.g        = 10'h137;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    check("srch_no_valid", 32'(dif.out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_in_ready", 32'(dif.in_ready), 32'd1);
    check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    check("midrst_code_out", 32'(dif.code_out), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(dif.out_valid), 32'd0);
    run_word(15'h0537, 10'h137, 0, 1'b0);

    // Randomized codewords with 0, 1 or 2 bit errors
    for (int i = 0; i < 40; i++) begin
      gv    = (i % 4 == 3) ? M'($urandom) : 10'h137;
      dword = N'($urandom_range(0, (1 << K) - 1)) << M;
      cw    = dword | N'(poly_mod(dword, gv));
      nerr  = $urandom_range(0, 2);
      b0    = $urandom_range(0, N - 1);
      b1    = (b0 + $urandom_range(1, N - 1)) % N;
      if (nerr >= 1) cw[b0] = ~cw[b0];
      if (nerr == 2) cw[b1] = ~cw[b1];
      run_word(cw, gv, $urandom_range(0, 2), (i % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
